// File: rtl/pulse_uart_tx_pkg.sv
// Shared constants and serializer state encoding for the pulse record UART transmitter.
package pulse_uart_tx_pkg;

    localparam int FRAME_BYTES        = 6;
    localparam int UART_BITS_PER_BYTE = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer: start bit goes out the cycle after a byte is accepted.
// byte_ready_o is high when idle and on the last stop-bit cycle, so a waiting byte chains with no gap.
module uart_tx_byte
    import pulse_uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_BITS     = 7
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_dat_i,
    output logic       byte_ready_o,
    output logic       tx_o
);

    localparam int DATA_BITS = UART_BITS_PER_BYTE - 2;

    uart_state_e         state_q, state_d;
    logic [CNT_BITS-1:0] baud_q, baud_d;
    logic [2:0]          bit_q, bit_d;
    logic [7:0]          sh_q, sh_d;
    logic                tx_q, tx_d;
    logic                baud_last;

    assign baud_last    = (baud_q == CNT_BITS'(CLKS_PER_BIT - 1));
    assign byte_ready_o = (state_q == IDLE) || ((state_q == STOP) && baud_last);
    assign tx_o         = tx_q;

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        tx_d    = tx_q;
        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                baud_d = '0;
            end
            START: begin
                if (baud_last) begin
                    state_d = DATA;
                    baud_d  = '0;
                    bit_d   = '0;
                    tx_d    = sh_q[0];
                end else begin
                    baud_d = baud_q + CNT_BITS'(1);
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'(DATA_BITS - 1)) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                        tx_d  = sh_q[1];
                    end
                end else begin
                    baud_d = baud_q + CNT_BITS'(1);
                end
            end
            STOP: begin
                if (baud_last) begin
                    state_d = IDLE;
                    baud_d  = '0;
                    tx_d    = 1'b1;
                end else begin
                    baud_d = baud_q + CNT_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        // Accepting a byte overrides the stop-bit exit so the next start bit follows directly.
        if (byte_valid_i && byte_ready_o) begin
            state_d = START;
            baud_d  = '0;
            sh_d    = byte_dat_i;
            tx_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

endmodule

// File: rtl/pulse_uart_tx.sv
// Pops one pulse record (ts + length) and sends it as a byte frame on an 8N1 line; start bit the cycle after the pop.
// in_ready is high only while idle; PULSE_UART_CHECKSUM_EN appends an XOR checksum byte.
module pulse_uart_tx
    import pulse_uart_tx_pkg::*;
#(
    parameter int TS_WIDTH     = 32,
    parameter int LEN_WIDTH    = 16,
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_BITS     = 7
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 in_valid,
    input  logic [TS_WIDTH-1:0]  in_ts,
    input  logic [LEN_WIDTH-1:0] in_length,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy,
    output logic [15:0]          frame_count
);

`ifdef PULSE_UART_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES);
`else
    localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);
`endif
    // Byte 0 goes straight from in_length to the serializer, so only the remaining bytes are held.
    localparam int SH_W = TS_WIDTH + LEN_WIDTH - 8;

    logic            active_q, active_d;
    logic            rdy_q, rdy_d;
    logic [2:0]      byte_idx_q, byte_idx_d;
    logic [SH_W-1:0] shift_q, shift_d;
    logic [15:0]     frame_count_q, frame_count_d;
`ifdef PULSE_UART_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    logic       take, more, handoff, frame_end;
    logic       byte_valid, byte_ready;
    logic [7:0] byte_dat;

    assign take      = in_valid && rdy_q;
    assign more      = active_q && (byte_idx_q != LAST_IDX);
    assign handoff   = more && byte_ready;
    assign frame_end = active_q && byte_ready && (byte_idx_q == LAST_IDX);
    assign byte_valid = take || more;

    always_comb begin
        byte_dat = shift_q[7:0];
        if (take) begin
            byte_dat = in_length[7:0];
        end
`ifdef PULSE_UART_CHECKSUM_EN
        else if (byte_idx_q == LAST_IDX - 3'd1) begin
            byte_dat = csum_q;
        end
`endif
    end

    always_comb begin
        active_d      = active_q;
        byte_idx_d    = byte_idx_q;
        shift_d       = shift_q;
        frame_count_d = frame_count_q;
`ifdef PULSE_UART_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        if (take) begin
            active_d   = 1'b1;
            byte_idx_d = '0;
            shift_d    = {in_ts, in_length[LEN_WIDTH-1:8]};
`ifdef PULSE_UART_CHECKSUM_EN
            csum_d     = in_length[7:0];
`endif
        end else if (handoff) begin
            byte_idx_d = byte_idx_q + 3'd1;
            shift_d    = shift_q >> 8;
`ifdef PULSE_UART_CHECKSUM_EN
            csum_d     = csum_q ^ byte_dat;
`endif
        end else if (frame_end) begin
            active_d      = 1'b0;
            frame_count_d = frame_count_q + 16'd1;
        end
        rdy_d = !active_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q      <= 1'b0;
            rdy_q         <= 1'b0;
            byte_idx_q    <= '0;
            shift_q       <= '0;
            frame_count_q <= '0;
        end else begin
            active_q      <= active_d;
            rdy_q         <= rdy_d;
            byte_idx_q    <= byte_idx_d;
            shift_q       <= shift_d;
            frame_count_q <= frame_count_d;
        end
    end

`ifdef PULSE_UART_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_BITS     (CNT_BITS)
    ) u_byte (
        .clk          (clk),
        .reset_n      (reset_n),
        .byte_valid_i (byte_valid),
        .byte_dat_i   (byte_dat),
        .byte_ready_o (byte_ready),
        .tx_o         (tx)
    );

    assign in_ready    = rdy_q;
    assign busy        = active_q;
    assign frame_count = frame_count_q;

endmodule
